// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   Architectural integer register file with a busy (scoreboard) bit per
//   register. Two combinational read ports with same-cycle writeback bypass,
//   one writeback port, and issue/flush tracking of outstanding writes.
//
// Parameters
//   WORD_SIZE  data width of every register
//   NUM_REGS   number of architectural registers
//   REG_SEL    register index width
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-high reset (clears data and busy)
//   rs1, rs2        read indices
//   rs1_data        read data A (bypassed from writeback when rd == rs1)
//   rs2_data        read data B (bypassed from writeback when rd == rs2)
//   rd              writeback destination index
//   write_data      writeback data
//   reg_write       writeback enable
//   issue_valid     an instruction issues this cycle
//   issue_rd        destination of the issuing instruction
//   issue_reg_write issuing instruction writes issue_rd
//   flush           discard all in-flight writes (clears every busy bit)
//   rs1_busy        rs1 has an outstanding write not being retired now
//   rs2_busy        rs2 has an outstanding write not being retired now
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_SEL-1:0]   rs1,
    input  logic [REG_SEL-1:0]   rs2,
    output logic [WORD_SIZE-1:0] rs1_data,
    output logic [WORD_SIZE-1:0] rs2_data,
    input  logic [REG_SEL-1:0]   rd,
    input  logic [WORD_SIZE-1:0] write_data,
    input  logic                 reg_write,
    input  logic                 issue_valid,
    input  logic [REG_SEL-1:0]   issue_rd,
    input  logic                 issue_reg_write,
    input  logic                 flush,
    output logic                 rs1_busy,
    output logic                 rs2_busy
);

    // An index addresses real, writable state only if it is non-zero and
    // inside the implemented register range. Everything else behaves as x0.
    function automatic logic idx_ok(input logic [REG_SEL-1:0] idx);
        logic [31:0] idx_w;
        idx_w  = 32'(idx);
        idx_ok = (idx != {REG_SEL{1'b0}}) && (idx_w < 32'(NUM_REGS));
    endfunction

    logic [WORD_SIZE-1:0] regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_r;
    logic [NUM_REGS-1:0]  busy_nxt_s;
    logic                 wr_en_s;
    logic                 issue_en_s;

    // Qualified writeback/issue strobes; both are suppressed while in reset
    // so that a bypass cannot leak write_data during reset.
    always_comb begin
        wr_en_s    = 1'b0;
        issue_en_s = 1'b0;
        if (!rst) begin
            wr_en_s    = reg_write && idx_ok(rd);
            issue_en_s = issue_valid && issue_reg_write && idx_ok(issue_rd);
        end else begin
            wr_en_s    = 1'b0;
            issue_en_s = 1'b0;
        end
    end

    // Read port A: x0/out-of-range reads 0, else bypass, else stored value.
    always_comb begin
        rs1_data = {WORD_SIZE{1'b0}};
        rs1_busy = 1'b0;
        if (idx_ok(rs1)) begin
            if (wr_en_s && (rd == rs1)) begin
                rs1_data = write_data;
                rs1_busy = 1'b0;
            end else begin
                rs1_data = regs_r[rs1];
                rs1_busy = busy_r[rs1];
            end
        end else begin
            rs1_data = {WORD_SIZE{1'b0}};
            rs1_busy = 1'b0;
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        rs2_data = {WORD_SIZE{1'b0}};
        rs2_busy = 1'b0;
        if (idx_ok(rs2)) begin
            if (wr_en_s && (rd == rs2)) begin
                rs2_data = write_data;
                rs2_busy = 1'b0;
            end else begin
                rs2_data = regs_r[rs2];
                rs2_busy = busy_r[rs2];
            end
        end else begin
            rs2_data = {WORD_SIZE{1'b0}};
            rs2_busy = 1'b0;
        end
    end

    // Next busy vector: retire clears first so a same-index issue wins;
    // flush overrides everything.
    always_comb begin
        busy_nxt_s = busy_r;
        if (flush) begin
            busy_nxt_s = {NUM_REGS{1'b0}};
        end else begin
            if (wr_en_s) begin
                busy_nxt_s[rd] = 1'b0;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
            if (issue_en_s) begin
                busy_nxt_s[issue_rd] = 1'b1;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
        end
    end

    // Register storage; x0 is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {WORD_SIZE{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[rd] <= write_data;
        end
    end

    // Busy bit storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

endmodule
